// File: rtl/rf_pkg.sv
// Shared types and constants for the scoreboarded register file.
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file bus: two read ports, one write port, issue tracking and status.
// Reads and pend outputs are combinational from the addresses; writes and issues
// take effect on the rising clock edge, only while ready=1.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
);
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [AW-1:0]   a3;
  logic            we3;
  logic [XLEN-1:0] wd3;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            pend1;
  logic            pend2;
  logic            ready;
  rf_state_t       state;

  modport master (
    output a1, a2, a3, we3, wd3, iss_en, iss_rd,
    input  rd1, rd2, pend1, pend2, ready, state
  );

  modport slave (
    input  a1, a2, a3, we3, wd3, iss_en, iss_rd,
    output rd1, rd2, pend1, pend2, ready, state
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits; an issue to r sets, a writeback to r clears, and a
// same-edge issue beats the clear. Optional macro RF_BYPASS_EN hides pend early.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_en,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rd,
  input  logic          we3,
  input  logic [AW-1:0] a3,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic          pend1,
  output logic          pend2
);
  logic [NREGS-1:0] pending;
  logic             wb_valid;

  assign wb_valid = clr_en && we3 && (a3 != AW'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        // the issuing instruction is younger than the one writing back
        if (iss_en && (iss_rd == AW'(r)))
          pending[r] <= 1'b1;
        else if (wb_valid && (a3 == AW'(r)))
          pending[r] <= 1'b0;
      end
    end
  end

`ifdef RF_BYPASS_EN
  assign pend1 = pending[a1] && !(wb_valid && (a1 == a3));
  assign pend2 = pending[a2] && !(wb_valid && (a2 == a3));
`else
  assign pend1 = pending[a1];
  assign pend2 = pending[a2];
`endif
endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with post-reset clear sequencer and pending scoreboard.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  reg_file_sb_if.slave       bus
);
  logic [XLEN-1:0] regs [NREGS];
  rf_state_t       state, state_n;
  logic [AW:0]     clr_cnt;
  logic            active;
  logic            sb_pend1, sb_pend2;
  logic [XLEN-1:0] rdata1, rdata2;

  assign active = (state == RF_READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == RF_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    if ((state == RF_INIT) && (clr_cnt == (AW+1)'(NREGS - 1))) state_n = RF_READY;
  end

  // storage is only ever cleared by the sequencer, never by rst directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_INIT)
        regs[clr_cnt[AW-1:0]] <= '0;
      else if (bus.we3 && (bus.a3 != AW'(REG_ZERO)))
        regs[bus.a3] <= bus.wd3;
    end
  end

  always_comb begin
    rdata1 = regs[bus.a1];
    rdata2 = regs[bus.a2];
`ifdef RF_BYPASS_EN
    if (bus.we3 && (bus.a3 != AW'(REG_ZERO)) && (bus.a1 == bus.a3)) rdata1 = bus.wd3;
    if (bus.we3 && (bus.a3 != AW'(REG_ZERO)) && (bus.a2 == bus.a3)) rdata2 = bus.wd3;
`endif
  end

  rf_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .clr_en (active),
    .iss_en (bus.iss_en && active),
    .iss_rd (bus.iss_rd),
    .we3    (bus.we3),
    .a3     (bus.a3),
    .a1     (bus.a1),
    .a2     (bus.a2),
    .pend1  (sb_pend1),
    .pend2  (sb_pend2)
  );

  assign bus.ready = active && !rst;
  assign bus.state = state;
  assign bus.rd1   = (bus.ready && (bus.a1 != AW'(REG_ZERO))) ? rdata1 : '0;
  assign bus.rd2   = (bus.ready && (bus.a2 != AW'(REG_ZERO))) ? rdata2 : '0;
  assign bus.pend1 = bus.ready && sb_pend1;
  assign bus.pend2 = bus.ready && sb_pend2;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: init sequencing, read/write, x0, scoreboard, bypass, resets.
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
    bus.we3 = 1'b0; bus.wd3 = '0;
    bus.iss_en = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!bus.ready && edges < 200);
  endtask

  task automatic test_reset();
    int edges;
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.ready !== 1'b0 || bus.rd1 !== '0 || bus.pend1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b rd1=%h pend1=%b, want 0/0/0", bus.ready, bus.rd1, bus.pend1);
    end
    rst = 1'b0;
    wait_ready(edges);
    tests_run++;
    if (edges !== 32) begin
      tests_failed++;
      $display("FAIL init_latency: ready after %0d edges, want 32", edges);
    end
    tests_run++;
    if (bus.state !== RF_READY) begin
      tests_failed++;
      $display("FAIL init_state: state=%0d, want RF_READY", bus.state);
    end
    for (int i = 0; i < NREGS; i++) begin
      bus.a1 = AW'(i);
      bus.a2 = AW'(NREGS - 1 - i);
      #1;
      tests_run++;
      if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL init_clear x%0d: rd1=%h rd2=%h, want 0", i, bus.rd1, bus.rd2);
      end
    end
  endtask

  task automatic test_write_read();
    bus.we3 = 1'b1; bus.a3 = 5'd1; bus.wd3 = 32'h0000FFFF;
    tick();
    bus.a3 = 5'd2; bus.wd3 = 32'hFFFF0000;
    tick();
    bus.we3 = 1'b0;
    bus.a1 = 5'd1; bus.a2 = 5'd2;
    #1;
    tests_run++;
    if (bus.rd1 !== 32'h0000FFFF || bus.rd2 !== 32'hFFFF0000) begin
      tests_failed++;
      $display("FAIL write_read: rd1=%h rd2=%h, want 0000ffff ffff0000", bus.rd1, bus.rd2);
    end
  endtask

  task automatic test_x0();
    bus.we3 = 1'b1; bus.a3 = 5'd0; bus.wd3 = 32'hDEADBEEF;
    tick();
    bus.we3 = 1'b0; bus.a1 = 5'd0;
    #1;
    tests_run++;
    if (bus.rd1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_write: rd1=%h, want 0", bus.rd1);
    end
    bus.iss_en = 1'b1; bus.iss_rd = 5'd0;
    tick();
    bus.iss_en = 1'b0;
    #1;
    tests_run++;
    if (bus.pend1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_pend: pend1=%b, want 0", bus.pend1);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_pend_mid;
    logic [XLEN-1:0] exp_rd_mid;
`ifdef RF_BYPASS_EN
    exp_pend_mid = 1'b0; exp_rd_mid = 32'd7;
`else
    exp_pend_mid = 1'b1; exp_rd_mid = 32'd0;
`endif
    bus.a1 = 5'd5; bus.a2 = 5'd5;
    bus.iss_en = 1'b1; bus.iss_rd = 5'd5;
    #1;
    tests_run++;
    if (bus.pend1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_no_forward: pend1=%b, want 0", bus.pend1);
    end
    tick();
    bus.iss_en = 1'b0;
    #1;
    tests_run++;
    if (bus.pend1 !== 1'b1 || bus.pend2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_set: pend1=%b pend2=%b, want 1 1", bus.pend1, bus.pend2);
    end
    bus.we3 = 1'b1; bus.a3 = 5'd5; bus.wd3 = 32'd7;
    #1;
    tests_run++;
    if (bus.pend1 !== exp_pend_mid || bus.rd1 !== exp_rd_mid) begin
      tests_failed++;
      $display("FAIL sb_wb_same_cycle: pend1=%b rd1=%h, want %b %h", bus.pend1, bus.rd1, exp_pend_mid, exp_rd_mid);
    end
    tick();
    bus.we3 = 1'b0;
    #1;
    tests_run++;
    if (bus.pend1 !== 1'b0 || bus.rd1 !== 32'd7) begin
      tests_failed++;
      $display("FAIL sb_clear: pend1=%b rd1=%h, want 0 00000007", bus.pend1, bus.rd1);
    end
    bus.iss_en = 1'b1; bus.iss_rd = 5'd5;
    tick();
    bus.we3 = 1'b1; bus.a3 = 5'd5; bus.wd3 = 32'd9;
    tick();
    bus.iss_en = 1'b0; bus.we3 = 1'b0;
    #1;
    tests_run++;
    if (bus.pend1 !== 1'b1 || bus.rd1 !== 32'd9) begin
      tests_failed++;
      $display("FAIL sb_set_wins: pend1=%b rd1=%h, want 1 00000009", bus.pend1, bus.rd1);
    end
    bus.we3 = 1'b1; bus.a3 = 5'd5; bus.wd3 = 32'd9;
    tick();
    bus.we3 = 1'b0;
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp_mid;
`ifdef RF_BYPASS_EN
    exp_mid = 32'h12345678;
`else
    exp_mid = 32'h0;
`endif
    bus.we3 = 1'b1; bus.a3 = 5'd3; bus.wd3 = 32'h12345678;
    bus.a1 = 5'd3; bus.a2 = 5'd2;
    #1;
    tests_run++;
    if (bus.rd1 !== exp_mid || bus.rd2 !== 32'hFFFF0000) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: rd1=%h rd2=%h, want %h ffff0000", bus.rd1, bus.rd2, exp_mid);
    end
    tick();
    bus.we3 = 1'b0;
    #1;
    tests_run++;
    if (bus.rd1 !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL bypass_after_edge: rd1=%h, want 12345678", bus.rd1);
    end
  endtask

  task automatic test_reset_mid_init();
    int edges;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(edges);
    tests_run++;
    if (edges !== 32) begin
      tests_failed++;
      $display("FAIL reset_mid_init: ready after %0d edges, want 32", edges);
    end
  endtask

  task automatic test_reset_mid_op();
    int edges;
    bus.iss_en = 1'b1; bus.iss_rd = 5'd4;
    tick();
    bus.iss_en = 1'b0;
    bus.we3 = 1'b1; bus.a3 = 5'd6; bus.wd3 = 32'd1;
    tick();
    bus.we3 = 1'b0;
    bus.a1 = 5'd4; bus.a2 = 5'd6;
    #1;
    tests_run++;
    if (bus.pend1 !== 1'b1 || bus.rd2 !== 32'd1) begin
      tests_failed++;
      $display("FAIL pre_reset_state: pend1=%b rd2=%h, want 1 00000001", bus.pend1, bus.rd2);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.ready !== 1'b0 || bus.rd2 !== 32'h0 || bus.pend1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_gates_outputs: ready=%b rd2=%h pend1=%b, want 0 0 0", bus.ready, bus.rd2, bus.pend1);
    end
    tick();
    rst = 1'b0;
    wait_ready(edges);
    #1;
    tests_run++;
    if (edges !== 32 || bus.pend1 !== 1'b0 || bus.rd2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: edges=%0d pend1=%b rd2=%h, want 32 0 0", edges, bus.pend1, bus.rd2);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_bypass();
    test_reset_mid_init();
    idle_inputs();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the pipelined RISC-V core; successor to the single-cycle register file.
- Two asynchronous read ports and one synchronous write port.
- x0 is hardwired to zero.
- Adds a hardware clear sequencer after reset and a per-register pending scoreboard, which the hazard unit uses for stall decisions.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, ≥4.
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- a1  in  AW  read address, port 1.
- a2  in  AW  read address, port 2.
- rd1  out  XLEN  read data, port 1.
- rd2  out  XLEN  read data, port 2.
- a3  in  AW  write address.
- we3  in  1  write enable.
- wd3  in  XLEN  write data.
- iss_en  in  1  an instruction with destination iss_rd issues this cycle.
- iss_rd  in  AW  destination register of the issuing instruction.
- pend1  out  1  register a1 has an outstanding write.
- pend2  out  1  register a2 has an outstanding write.
- ready  out  1  clear sequence done; file is usable.

Behaviour:
- Reset: one clk and one reset (rst), synchronous, active-high.
  - Edge with rst=1: state<=INIT, clr_cnt<=0, pending[] <= all 0.
  - Register contents are not touched by rst itself.
  - Outputs while rst=1 or in INIT: ready=0, rd1=rd2=0, pend1=pend2=0.
- FSM, two states:
  - INIT: each edge writes reg[clr_cnt]<=0 and increments clr_cnt. On the edge where clr_cnt==NREGS-1, go to READY.
  - READY: normal operation. Stay in READY until rst.
  - ready=1 only in READY. It rises exactly NREGS edges after the first edge with rst=0.
- Reset mid-INIT: restarts at clr_cnt=0.
- In INIT, we3, iss_en and writeback-clear are ignored.
- Read (READY):
  - rd1=reg[a1], rd2=reg[a2], combinational.
  - Address 0 always reads 0.
- Write (READY): on an edge with we3=1 and a3≠0, reg[a3]<=wd3. a3=0 is a no-op.
- Scoreboard (READY), for each r≠0:
  - iss_en=1 and iss_rd=r sets pending[r].
  - we3=1 and a3=r clears pending[r].
  - Both in the same edge on the same r: set wins, because the new producer is younger.
  - pending[0] is permanently 0; iss_rd=0 is ignored.
- pend1=pending[a1], pend2=pending[a2], combinational. These use the registered pending value only; no same-cycle forwarding of iss_en.
- Simultaneous read/write of the same address without the optional feature: rd returns the old value until the edge.
- Width rules: addresses ≥NREGS cannot occur (AW exact). No arithmetic beyond clr_cnt, which is AW+1 bits wide so the terminal compare cannot wrap.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - When we3=1, a3≠0 and a1==a3, rd1=wd3 in the same cycle; likewise rd2 when a2==a3.
  - pend1/pend2 are forced low for that register in that cycle, because the clear is visible early.
  - This removes the write-then-read bubble for the decode stage.
- Undefined: pure register-file semantics as described in Behaviour; the old value is returned and pend stays high until after the edge.

Decomposition:
- Package rf_pkg holds:
  - XLEN_DEF=32 and NREGS_DEF=32.
  - typedef rf_state_t {RF_INIT, RF_READY}.
  - Constant REG_ZERO=0.
- One sub-module, rf_scoreboard:
  - Holds the pending bit vector plus set/clear priority.
  - Ports: clk, rst, clr_en, iss_en, iss_rd, we3, a3, a1, a2, pend1, pend2.
- The storage array and clear FSM stay in reg_file_sb.

Test Plan:
- Reset and init: rst=1 for 1 edge, then rst=0.
  - ready=0 for 32 edges, then 1.
  - Every register then reads 0x00000000.
- Write/read: we3=1, a3=1, wd3=0x0000FFFF; next cycle a3=2, wd3=0xFFFF0000; then a1=1, a2=2.
  - rd1=0x0000FFFF, rd2=0xFFFF0000.
- x0 immutability: we3=1, a3=0, wd3=0xDEADBEEF; then a1=0 → rd1=0.
  - iss_en=1, iss_rd=0 with a1=0 → pend1=0.
- Scoreboard:
  - iss_en=1, iss_rd=5; next cycle a1=5 → pend1=1.
  - Then we3=1, a3=5, wd3=7 → after the edge pend1=0 and rd1=7.
  - Same edge iss_rd=5 with we3/a3=5 → pend1 remains 1.
- Bypass:
  - With RF_BYPASS_EN: we3=1, a3=3, wd3=0x12345678, a1=3 in the same cycle → rd1=0x12345678 before the edge.
  - Without RF_BYPASS_EN: rd1 shows the old value, 0.
- Reset mid-init and mid-operation:
  - Assert rst at clr_cnt=10 → ready stays 0 for a further 32 edges after release.
  - Set pending[4], write x6=1, then assert rst → after init, pend(4)=0 and x6 reads 0.
